// File: rtl/nonce_scanner.sv
//==============================================================================
// Module   : nonce_scanner
// Brief    : Control stage around a double-SHA-256 pipeline. Walks a 32-bit
//            nonce range issuing one padded second block per cycle, tags the
//            returning digests with their nonce, compares each against the
//            difficulty target and reports the first hit or range exhaustion.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nonce_scanner #(
    // Cycles from a block2 value being presented to its digest on hash_in (>= 1)
    parameter int PIPE_LATENCY = 130
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [0:95]  header_tail,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic [0:511] block2,
    input  logic [0:255] hash_in,
    output logic         busy,
    output logic         result_valid,
    output logic         result_hit,
    output logic [31:0]  result_nonce
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t                  r_state;
    logic [0:95]             r_hdr;
    logic [31:0]             r_issue;
    logic [31:0]             r_check;
    logic [31:0]             r_end;
    logic [255:0]            r_target;
    logic [PIPE_LATENCY-1:0] r_vp;
    logic [0:511]            r_block2;
    logic                    r_busy;
    logic                    r_rv;
    logic                    r_hit;
    logic [31:0]             r_res_nonce;

    logic [PIPE_LATENCY-1:0] w_vp_fill;
    logic [PIPE_LATENCY-1:0] w_vp_drain;
    logic [255:0]            w_hash_value;
    logic                    w_check;
    logic                    w_hit;

    // Second header block: tail words, nonce, SHA padding bit, length = 640 bits
    function automatic logic [0:511] build_block2(input logic [0:95] hdr,
                                                  input logic [31:0] nonce);
        return {hdr, nonce, 1'b1, 319'd0, 64'd640};
    endfunction

    // Valid-pipe next values for the issuing (shift in 1) and draining (shift in 0) cases
    generate
        if (PIPE_LATENCY == 1) begin : g_vp_single
            assign w_vp_fill  = 1'b1;
            assign w_vp_drain = 1'b0;
        end else begin : g_vp_multi
            assign w_vp_fill  = {r_vp[PIPE_LATENCY-2:0], 1'b1};
            assign w_vp_drain = {r_vp[PIPE_LATENCY-2:0], 1'b0};
        end
    endgenerate

    // Digest byte k lands at hash_value[8k+7:8k]: the digest read as a little-endian number
    generate
        for (genvar k = 0; k < 32; k++) begin : g_byte_rev
            assign w_hash_value[8*k +: 8] = hash_in[8*k +: 8];
        end
    endgenerate

    assign w_check = r_vp[PIPE_LATENCY-1];
    assign w_hit   = w_check && (w_hash_value <= r_target);

    // Scan controller: issue, check, drain and report with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr       <= '0;
            r_issue     <= '0;
            r_check     <= '0;
            r_end       <= '0;
            r_target    <= '0;
            r_vp        <= '0;
            r_block2    <= '0;
            r_busy      <= 1'b0;
            r_rv        <= 1'b0;
            r_hit       <= 1'b0;
            r_res_nonce <= '0;
        end else begin
            r_rv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hdr       <= header_tail;
                        r_end       <= nonce_end;
                        r_target    <= target;
                        r_issue     <= nonce_start;
                        r_check     <= nonce_start;
                        r_block2    <= build_block2(header_tail, nonce_start);
                        r_hit       <= 1'b0;
                        r_res_nonce <= '0;
                        r_vp        <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (stop) begin
                        // Abort: stale in-flight digests must never be checked later
                        r_vp    <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        r_hit       <= 1'b1;
                        r_res_nonce <= r_check;
                        r_vp        <= '0;
                        r_busy      <= 1'b0;
                        r_rv        <= 1'b1;
                        r_state     <= S_REPORT;
                    end else begin
                        if (w_check) begin
                            r_check <= r_check + 32'd1;
                        end
                        if (r_state == S_RUN) begin
                            r_vp <= w_vp_fill;
                            if (r_issue == r_end) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_issue  <= r_issue + 32'd1;
                                r_block2 <= build_block2(r_hdr, r_issue + 32'd1);
                            end
                        end else begin
                            r_vp <= w_vp_drain;
                            // Last outstanding digest just checked without a hit
                            if (w_vp_drain == '0) begin
                                r_busy  <= 1'b0;
                                r_rv    <= 1'b1;
                                r_state <= S_REPORT;
                            end
                        end
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign block2       = r_block2;
    assign busy         = r_busy;
    assign result_valid = r_rv;
    assign result_hit   = r_hit;
    assign result_nonce = r_res_nonce;

endmodule

`default_nettype wire

// File: tb/tb_nonce_scanner.sv
//==============================================================================
// Module   : tb_nonce_scanner
// Brief    : Directed self-checking bench for nonce_scanner with a fixed-delay
//            stand-in for the hashing pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nonce_scanner;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic [0:95]  header_tail;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic [0:511] block2;
    logic [0:255] hash_in;
    logic         busy;
    logic         result_valid;
    logic         result_hit;
    logic [31:0]  result_nonce;

    int n_vec = 0;
    int n_err = 0;

    // Stand-in hash: all-ones digest except one programmable nonce
    logic         spec_en;
    logic [31:0]  spec_nonce;
    logic [0:255] spec_digest;
    logic [0:255] mdl_pipe [0:LAT-1];

    // Observations gathered while waiting for a result
    logic [31:0]  cap_nonce [1:16];
    logic         cap_busy  [1:16];
    logic [0:511] cap_b2;
    int           rv_cyc;
    int           rv_count;
    logic         rv_hit;
    logic [31:0]  rv_nonce;

    nonce_scanner #(.PIPE_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .header_tail  (header_tail),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .block2       (block2),
        .hash_in      (hash_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_hit   (result_hit),
        .result_nonce (result_nonce)
    );

    always #5 clk = ~clk;

    function automatic logic [0:255] model_digest(input logic [31:0] n);
        if (spec_en && n == spec_nonce) return spec_digest;
        return {256{1'b1}};
    endfunction

    // Fixed LAT-cycle delay from block2 to hash_in
    always @(posedge clk) begin
        mdl_pipe[0] <= model_digest(block2[96:127]);
        for (int i = 1; i < LAT; i++) mdl_pipe[i] <= mdl_pipe[i-1];
    end
    assign hash_in = mdl_pipe[LAT-1];

    task automatic start_scan(input logic [0:95] h, input logic [31:0] ns,
                              input logic [31:0] ne, input logic [255:0] tg);
        header_tail = h;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle 1 is the first RUN cycle; stops one cycle after the first result pulse
    task automatic wait_result(input int max_cyc);
        rv_cyc   = -1;
        rv_count = 0;
        rv_hit   = 1'bx;
        rv_nonce = 'x;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                cap_nonce[k] = block2[96:127];
                cap_busy[k]  = busy;
            end
            if (k == 1) cap_b2 = block2;
            if (result_valid === 1'b1) begin
                rv_count++;
                if (rv_cyc < 0) begin
                    rv_cyc   = k;
                    rv_hit   = result_hit;
                    rv_nonce = result_nonce;
                end
            end
            if (rv_cyc > 0 && k >= rv_cyc + 2) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; spec_en = 1'b0;
        spec_nonce = '0; spec_digest = '0;
        header_tail = '0; nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_vec++; if (result_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", result_hit); end
        n_vec++; if (result_nonce !== 32'd0) begin n_err++; $display("FAIL reset_nonce: got %h want 0", result_nonce); end
        n_vec++; if (block2 !== 512'd0) begin n_err++; $display("FAIL reset_block2: got nonzero block2 want 0"); end
    endtask

    task automatic test_basic_scan;
        logic [31:0] exp_n [1:5];
        exp_n = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13};
        spec_en = 1'b0;
        start_scan(96'h0123456789ABCDEF_DEADBEEF, 32'h10, 32'h13, 256'd0);
        wait_result(40);
        for (int k = 1; k <= 5; k++) begin
            n_vec++;
            if (cap_nonce[k] !== exp_n[k]) begin
                n_err++; $display("FAIL basic_issue_nonce[%0d]: got %h want %h", k, cap_nonce[k], exp_n[k]);
            end
        end
        n_vec++; if (cap_b2[0:95] !== 96'h0123456789ABCDEF_DEADBEEF) begin n_err++; $display("FAIL basic_hdr: got %h", cap_b2[0:95]); end
        n_vec++; if (cap_b2[128] !== 1'b1) begin n_err++; $display("FAIL basic_pad_bit: got %b want 1", cap_b2[128]); end
        n_vec++; if (cap_b2[129:447] !== 319'd0) begin n_err++; $display("FAIL basic_pad_zero: got nonzero want 0"); end
        n_vec++; if (cap_b2[448:511] !== 64'h280) begin n_err++; $display("FAIL basic_length: got %h want 280", cap_b2[448:511]); end
        n_vec++; if (cap_busy[1] !== 1'b1) begin n_err++; $display("FAIL basic_busy_c1: got %b want 1", cap_busy[1]); end
        n_vec++; if (cap_busy[8] !== 1'b1) begin n_err++; $display("FAIL basic_busy_c8: got %b want 1", cap_busy[8]); end
        n_vec++; if (cap_busy[9] !== 1'b0) begin n_err++; $display("FAIL basic_busy_c9: got %b want 0", cap_busy[9]); end
        n_vec++; if (rv_cyc !== 9) begin n_err++; $display("FAIL basic_rv_cycle: got %0d want 9", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b0) begin n_err++; $display("FAIL basic_hit: got %b want 0", rv_hit); end
        n_vec++; if (rv_count !== 1) begin n_err++; $display("FAIL basic_rv_pulses: got %0d want 1", rv_count); end
    endtask

    task automatic test_hit;
        spec_en = 1'b1; spec_nonce = 32'h12; spec_digest = '0;
        start_scan(96'hA5A5A5A5_5A5A5A5A_01020304, 32'h10, 32'h13, 256'd1);
        wait_result(40);
        n_vec++; if (rv_cyc !== 8) begin n_err++; $display("FAIL hit_rv_cycle: got %0d want 8", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b1) begin n_err++; $display("FAIL hit_flag: got %b want 1", rv_hit); end
        n_vec++; if (rv_nonce !== 32'h12) begin n_err++; $display("FAIL hit_nonce: got %h want 12", rv_nonce); end
        n_vec++; if (cap_busy[8] !== 1'b0) begin n_err++; $display("FAIL hit_busy_after: got %b want 0", cap_busy[8]); end
        n_vec++; if (rv_count !== 1) begin n_err++; $display("FAIL hit_rv_pulses: got %0d want 1", rv_count); end
        n_vec++; if (result_hit !== 1'b1 || result_nonce !== 32'h12) begin
            n_err++; $display("FAIL hit_held: got %b/%h want 1/12", result_hit, result_nonce);
        end
    endtask

    task automatic test_hit_on_last_issue;
        // Check of 0x23 coincides with the RUN cycle issuing 0x27
        spec_en = 1'b1; spec_nonce = 32'h23; spec_digest = '0;
        start_scan(96'h1, 32'h20, 32'h27, 256'd1);
        wait_result(40);
        n_vec++; if (rv_cyc !== 9) begin n_err++; $display("FAIL last_rv_cycle: got %0d want 9", rv_cyc); end
        n_vec++; if (rv_nonce !== 32'h23) begin n_err++; $display("FAIL last_nonce: got %h want 23", rv_nonce); end
        n_vec++; if (cap_busy[8] !== 1'b1) begin n_err++; $display("FAIL last_busy_c8: got %b want 1", cap_busy[8]); end
        n_vec++; if (cap_busy[9] !== 1'b0) begin n_err++; $display("FAIL last_no_drain: got busy %b want 0", cap_busy[9]); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_n [1:5];
        exp_n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1};
        spec_en = 1'b1; spec_nonce = 32'h0; spec_digest = '0;
        start_scan(96'h2, 32'hFFFFFFFE, 32'h00000001, 256'd1);
        wait_result(40);
        for (int k = 1; k <= 5; k++) begin
            n_vec++;
            if (cap_nonce[k] !== exp_n[k]) begin
                n_err++; $display("FAIL wrap_issue_nonce[%0d]: got %h want %h", k, cap_nonce[k], exp_n[k]);
            end
        end
        n_vec++; if (rv_cyc !== 8) begin n_err++; $display("FAIL wrap_rv_cycle: got %0d want 8", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b1 || rv_nonce !== 32'h0) begin
            n_err++; $display("FAIL wrap_hit_nonce: got %b/%h want 1/0", rv_hit, rv_nonce);
        end
    endtask

    task automatic test_byte_order;
        logic [0:255] d;
        // Least significant byte of the value: equals target, so hit
        d = '0; d[0:7] = 8'h01;
        spec_en = 1'b1; spec_nonce = 32'h50; spec_digest = d;
        start_scan(96'h3, 32'h50, 32'h50, 256'd1);
        wait_result(40);
        n_vec++; if (cap_nonce[2] !== 32'h50) begin n_err++; $display("FAIL single_issue: got %h want 50", cap_nonce[2]); end
        n_vec++; if (rv_cyc !== 6) begin n_err++; $display("FAIL bo_lsb_rv_cycle: got %0d want 6", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b1 || rv_nonce !== 32'h50) begin
            n_err++; $display("FAIL bo_lsb_hit: got %b/%h want 1/50", rv_hit, rv_nonce);
        end
        // Most significant byte of the value: far above target
        d = '0; d[248:255] = 8'h01;
        spec_digest = d;
        start_scan(96'h3, 32'h50, 32'h50, 256'd1);
        wait_result(40);
        n_vec++; if (rv_cyc !== 6) begin n_err++; $display("FAIL bo_msb_rv_cycle: got %0d want 6", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b0) begin n_err++; $display("FAIL bo_msb_hit: got %b want 0", rv_hit); end
    endtask

    task automatic test_stop;
        int seen_rv;
        int seen_busy;
        spec_en = 1'b0;
        start_scan(96'h4, 32'h100, 32'h1FF, 256'd0);
        @(posedge clk);
        #1 stop = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0; start = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
        seen_rv = 0; seen_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen_rv++;
            if (busy !== 1'b0) seen_busy++;
        end
        n_vec++; if (seen_rv !== 0) begin n_err++; $display("FAIL stop_no_result: got %0d pulses want 0", seen_rv); end
        n_vec++; if (seen_busy !== 0) begin n_err++; $display("FAIL stop_start_ignored: got %0d busy cycles want 0", seen_busy); end
        // Fresh scan after abort
        spec_en = 1'b1; spec_nonce = 32'h11; spec_digest = '0;
        start_scan(96'h5, 32'h10, 32'h13, 256'd1);
        wait_result(40);
        n_vec++; if (rv_cyc !== 7) begin n_err++; $display("FAIL stop_rescan_cycle: got %0d want 7", rv_cyc); end
        n_vec++; if (rv_hit !== 1'b1 || rv_nonce !== 32'h11) begin
            n_err++; $display("FAIL stop_rescan_hit: got %b/%h want 1/11", rv_hit, rv_nonce);
        end
    endtask

    task automatic test_reset_mid_drain;
        spec_en = 1'b0;
        start_scan(96'h6, 32'h10, 32'h13, 256'd0);
        repeat (6) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        n_vec++; if (block2 !== 512'd0) begin n_err++; $display("FAIL rst_async_block2: got nonzero want 0"); end
        n_vec++; if (result_valid !== 1'b0 || result_hit !== 1'b0 || result_nonce !== 32'd0) begin
            n_err++; $display("FAIL rst_async_result: got %b/%b/%h want 0/0/0", result_valid, result_hit, result_nonce);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_scan(96'h7, 32'h10, 32'h13, 256'd0);
        wait_result(40);
        n_vec++; if (cap_nonce[1] !== 32'h10) begin n_err++; $display("FAIL rst_rescan_first: got %h want 10", cap_nonce[1]); end
        n_vec++; if (rv_cyc !== 9 || rv_hit !== 1'b0) begin
            n_err++; $display("FAIL rst_rescan_result: got cycle %0d hit %b want 9/0", rv_cyc, rv_hit);
        end
    endtask

    initial begin
        test_reset;
        test_basic_scan;
        test_hit;
        test_hit_on_last_issue;
        test_wrap;
        test_byte_order;
        test_stop;
        test_reset_mid_drain;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nonce_scanner.md
Name: nonce_scanner

Overview:
- Upstream/downstream control stage for the double-SHA-256 hashing pipeline.
- Iterates a 32-bit nonce range and builds one padded second header block (block2) per cycle for the pipeline.
- Tags each returned final digest with its nonce and compares the digest against the difficulty target.
- Reports the first nonce whose hash meets the target, or reports range exhaustion.

Parameters:
- PIPE_LATENCY, 130: clock cycles from a block2 value being presented to its matching final digest appearing on hash_in. Must be ≥1.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begins a scan; sampled only in IDLE.
- stop, input, 1: aborts the scan; sampled in RUN and DRAIN.
- header_tail, input, [0:95]: merkle-root tail, ntime and nbits words; latched on start.
- nonce_start, input, [31:0]: first nonce; latched on start.
- nonce_end, input, [31:0]: last nonce, inclusive; latched on start.
- target, input, [255:0]: unsigned difficulty target; latched on start.
- block2, output, [0:511]: padded second block to the hashing pipeline.
- hash_in, input, [0:255]: final digest from the pipeline.
- busy, output, 1: high in RUN and DRAIN.
- result_valid, output, 1: one-cycle pulse when a scan completes.
- result_hit, output, 1: 1 if a qualifying nonce was found; held until the next start.
- result_nonce, output, [31:0]: the qualifying nonce; held until the next start.

Behaviour:
- Reset:
  - state = IDLE; block2 = all zeros; busy = 0; result_valid = 0; result_hit = 0; result_nonce = 0.
  - All valid-pipe bits and both counters are cleared.
  - Reset mid-scan discards all in-flight work.
- block2 layout:
  - [0:95] = latched header_tail.
  - [96:127] = issue nonce, MSB at bit 96. No byte swap is applied; software pre-swaps.
  - [128] = 1; [129:447] = 0.
  - [448:511] = 64'd640.
- State machine: IDLE, RUN, DRAIN, REPORT.
- IDLE:
  - start=1: latch inputs; issue_nonce = check_nonce = nonce_start; clear result_hit and result_nonce; go to RUN.
- RUN:
  - Each cycle: present block2 with issue_nonce and shift a 1 into the PIPE_LATENCY-deep valid pipe.
  - If issue_nonce == nonce_end: go to DRAIN. Otherwise issue_nonce += 1, wrapping modulo 2^32.
  - When nonce_end < nonce_start, the scan wraps through 0xFFFFFFFF to 0.
  - When nonce_start == nonce_end, exactly one nonce is issued.
- DRAIN:
  - A 0 is shifted into the valid pipe each cycle.
  - block2 keeps its last value.
- Check path (RUN and DRAIN):
  - Active when the valid-pipe output is 1.
  - Form hash_value[255:0] with byte k of the digest (hash_in[8k:8k+7]) placed at hash_value[8k+7:8k], i.e. the digest bytes reversed.
  - hit = (hash_value <= target), unsigned, full 256 bits.
  - On hit: result_hit = 1; result_nonce = check_nonce; flush the valid pipe; go to REPORT.
  - Otherwise check_nonce += 1, wrapping.
- Completion without a hit:
  - In DRAIN, once the valid pipe is empty and the last check was not a hit, go to REPORT with result_hit = 0.
- REPORT:
  - result_valid = 1 for one cycle, then go to IDLE.
- stop:
  - stop=1 in RUN or DRAIN: flush the valid pipe and go to IDLE with no result_valid.
  - stop wins over a hit in the same cycle.
  - A start in the same cycle as a stop is ignored.
- Simultaneous events:
  - A hit on the same cycle as the last issue goes to REPORT; no DRAIN occurs.
  - start while busy is ignored.
- Latency:
  - The first check occurs PIPE_LATENCY cycles after the first RUN cycle.
  - A range of N nonces with no hit pulses result_valid N+PIPE_LATENCY+1 cycles after start.

Test Plan:
- PIPE_LATENCY=4, hash model = fixed delay; nonce_start=0x10, nonce_end=0x13, target=0 -> block2[96:127] steps 0x10..0x13; padding bit 128 = 1; [448:511] = 0x280; result_valid with hit=0 at cycle 9.
- Same setup; model returns an all-zero digest for nonce 0x12, target=1 -> result_hit=1, result_nonce=0x12; no further nonces are checked after the hit.
- Wrap: nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> exactly 4 nonces issued: FFFFFFFE, FFFFFFFF, 0, 1.
- Byte order: digest with hash_in[0:7]=0x01 and all other bytes 0, target=1 -> hit. Digest with hash_in[248:255]=0x01, target=1 -> no hit.
- stop asserted 2 cycles into RUN -> busy falls next cycle; no result_valid; a new start then scans correctly.
- rst asserted mid-DRAIN -> all outputs return to reset values asynchronously; start after rst release behaves like the first scan.
